// File: rtl/img_top_pkg.sv
// Shared types and constants for the image pipeline top level,
// including the Gaussian frame sequencer FSM state encoding.
package img_top_pkg;

  localparam int PIX_PER_BEAT    = 8;
  localparam int GAUSS_K         = 5;
  localparam int MAX_W_BEATS_DEF = 240;
  localparam int MAX_H_DEF       = 1080;
  localparam int BEAT_CNT_W      = $clog2(MAX_W_BEATS_DEF + 1);
  localparam int ROW_CNT_W       = $clog2(MAX_H_DEF + 1);

  typedef enum logic [2:0] {
    G_IDLE  = 3'd0,
    G_PRIME = 3'd1,
    G_RUN   = 3'd2,
    G_DRAIN = 3'd3,
    G_DONE  = 3'd4
  } gctrl_state_e;

  // A frame needs at least two beats per row and a full kernel height of rows.
  function automatic logic cfg_in_range(input int w, input int h,
                                        input int max_w, input int max_h);
    return (w >= 2) && (w <= max_w) && (h >= GAUSS_K) && (h <= max_h);
  endfunction

endpackage

// File: rtl/gctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear and flush.
module gctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for the 5x5 Gaussian stage: drives line buffer write/read
// controls and row rotation, and emits core valid plus aligned sof/eol markers.
module gaussian_frame_ctrl
  import img_top_pkg::*;
#(
  parameter  int MAX_W_BEATS = 240,
  parameter  int MAX_H       = 1080,
  parameter  int LB_LAT      = 1,
  parameter  int CORE_LAT    = 1,
  localparam int CW_W        = $clog2(MAX_W_BEATS + 1),
  localparam int CH_W        = $clog2(MAX_H + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [CW_W-1:0] i_cfg_w_beats,
  input  logic [CH_W-1:0] i_cfg_h,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_in_sof,
  input  logic            i_in_eol,
  output logic            o_lb_wr_en,
  output logic [1:0]      o_lb_row_sel,
  output logic            o_lb_rd_en,
  output logic            o_core_in_valid,
  output logic            o_out_sof,
  output logic            o_out_eol,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output gctrl_state_e    o_dbg_state
);

  localparam int DRAIN_CYC = LB_LAT + CORE_LAT;
  localparam int DR_W      = $clog2(DRAIN_CYC + 1);

  gctrl_state_e    r_state, w_next;
  logic [CW_W-1:0] r_w, r_col;
  logic [CH_W-1:0] r_h, r_row;
  logic [1:0]      r_row_sel;
  logic [DR_W-1:0] r_drain_cnt;
  logic            r_err, r_in_ready;

  logic w_acc, w_cfg_ok, w_start_ok, w_start_bad;
  logic w_first, w_last_col, w_perr, w_row_end;
  logic w_sof_mk, w_eol_mk;
  logic [1:0] w_mk_q;

  // Input handshake: a beat transfers in any cycle where i_in_valid && o_in_ready.
  // o_in_ready is a register derived from the FSM state only; it never looks at i_in_valid.
  assign w_acc       = i_in_valid && r_in_ready;
  assign w_cfg_ok    = cfg_in_range(int'(i_cfg_w_beats), int'(i_cfg_h), MAX_W_BEATS, MAX_H);
  assign w_start_ok  = i_start && (r_state == G_IDLE) && w_cfg_ok;
  assign w_start_bad = i_start && (r_state == G_IDLE) && !w_cfg_ok;
  assign w_first     = (r_row == '0) && (r_col == '0);
  assign w_last_col  = (r_col == r_w - 1'b1);
  assign w_perr      = w_acc && ((i_in_sof != w_first) || (i_in_eol != w_last_col));
  assign w_row_end   = w_acc && !w_perr && w_last_col;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= G_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      G_IDLE:  if (w_start_ok) w_next = G_PRIME;
      G_PRIME: begin
        if (w_perr) w_next = G_IDLE;
        else if (w_row_end && (r_row == CH_W'(GAUSS_K - 2))) w_next = G_RUN;
      end
      G_RUN: begin
        if (w_perr) w_next = G_IDLE;
        else if (w_row_end && (r_row == r_h - 1'b1)) w_next = G_DRAIN;
      end
      G_DRAIN: if (r_drain_cnt == DR_W'(DRAIN_CYC - 1)) w_next = G_DONE;
      G_DONE:  w_next = G_IDLE;
      default: w_next = G_IDLE;
    endcase
  end

  // Column 0 only fills the line buffer; its window lacks a left halo.
  always_comb begin
    o_lb_wr_en = w_acc && !w_perr;
    o_lb_rd_en = w_acc && !w_perr && (r_state == G_RUN) && (r_col != '0);
    w_sof_mk   = o_lb_rd_en && (r_row == CH_W'(GAUSS_K - 1)) && (r_col == CW_W'(1));
    w_eol_mk   = o_lb_rd_en && w_last_col;
    o_busy     = (r_state == G_PRIME) || (r_state == G_RUN) || (r_state == G_DRAIN);
    o_done     = (r_state == G_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_w         <= '0;
      r_h         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_row_sel   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == G_PRIME) || (w_next == G_RUN);
      r_drain_cnt <= (r_state == G_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_start_ok) begin
        r_w       <= i_cfg_w_beats;
        r_h       <= i_cfg_h;
        r_col     <= '0;
        r_row     <= '0;
        r_row_sel <= '0;
        r_err     <= 1'b0;
      end else if (w_start_bad) begin
        r_err <= 1'b1;
      end
      if (w_perr) begin
        r_err <= 1'b1;
        r_col <= '0;
        r_row <= '0;
      end else if (w_acc) begin
        if (w_last_col) begin
          r_col     <= '0;
          r_row     <= r_row + 1'b1;
          r_row_sel <= r_row_sel + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // A protocol error flushes both lines so no partial frame leaks downstream.
  gctrl_delay_line #(.DEPTH(LB_LAT), .WIDTH(1)) u_vld_dl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_perr),
    .i_d     (o_lb_rd_en),
    .o_q     (o_core_in_valid)
  );

  gctrl_delay_line #(.DEPTH(LB_LAT + CORE_LAT), .WIDTH(2)) u_mk_dl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_perr),
    .i_d     ({w_sof_mk, w_eol_mk}),
    .o_q     (w_mk_q)
  );

  assign o_out_sof    = w_mk_q[1];
  assign o_out_eol    = w_mk_q[0];
  assign o_in_ready   = r_in_ready;
  assign o_lb_row_sel = r_row_sel;
  assign o_err        = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Directed bench for gaussian_frame_ctrl: a driver pushes expected output
// markers and cycles into a queue, a monitor pops them on each core output beat.
module tb_gaussian_frame_ctrl;
  import img_top_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [7:0]   i_cfg_w_beats;
  logic [10:0]  i_cfg_h;
  logic         i_in_valid;
  logic         o_in_ready;
  logic         i_in_sof;
  logic         i_in_eol;
  logic         o_lb_wr_en;
  logic [1:0]   o_lb_row_sel;
  logic         o_lb_rd_en;
  logic         o_core_in_valid;
  logic         o_out_sof;
  logic         o_out_eol;
  logic         o_busy;
  logic         o_done;
  logic         o_err;
  gctrl_state_e o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int out_cnt = 0;
  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       core_ov = 1'b0;
  logic [1:0] mon_e;
  int         mon_c;

  gaussian_frame_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_cfg_w_beats   (i_cfg_w_beats),
    .i_cfg_h         (i_cfg_h),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .i_in_sof        (i_in_sof),
    .i_in_eol        (i_in_eol),
    .o_lb_wr_en      (o_lb_wr_en),
    .o_lb_row_sel    (o_lb_row_sel),
    .o_lb_rd_en      (o_lb_rd_en),
    .o_core_in_valid (o_core_in_valid),
    .o_out_sof       (o_out_sof),
    .o_out_eol       (o_out_eol),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_dbg_state     (o_dbg_state)
  );

  // Clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // One-cycle core model: out_valid follows in_valid; reset clears it.
  always @(posedge i_clk) core_ov <= i_rst_n ? o_core_in_valid : 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (core_ov) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: output beat at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("out_markers", int'({o_out_sof, o_out_eol}), int'(mon_e));
        chk("out_cycle", cyc, mon_c);
      end
    end else if (o_out_sof || o_out_eol) begin
      chk("stray_marker", int'({o_out_sof, o_out_eol}), 0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, int'({o_in_ready, o_lb_wr_en, o_lb_row_sel, o_lb_rd_en,
                              o_core_in_valid, o_out_sof, o_out_eol, o_busy,
                              o_done, o_err}), 0);
    chk({tag, "_state"}, int'(o_dbg_state), int'(G_IDLE));
  endtask

  task automatic do_start(input int w, input int h);
    i_start       = 1'b1;
    i_cfg_w_beats = 8'(w);
    i_cfg_h       = 11'(h);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_beat(input int r, input int c, input int w,
                           input bit gap, input bit bad_eol);
    bit rd_exp;
    if (gap) begin
      i_in_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b1;
    i_in_sof   = (r == 0 && c == 0);
    i_in_eol   = (c == w - 1) ^ bad_eol;
    @(negedge i_clk);
    chk("in_ready", o_in_ready, 1);
    if (!bad_eol) begin
      rd_exp = (r >= 4 && c >= 1);
      chk("lb_wr_en", o_lb_wr_en, 1);
      chk("lb_rd_en", o_lb_rd_en, rd_exp);
      chk("lb_row_sel", o_lb_row_sel, r % 4);
      if (rd_exp) begin
        exp_q.push_back({(r == 4 && c == 1), (c == w - 1)});
        exp_cyc_q.push_back(cyc + 2);
      end
    end
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_in_sof   = 1'b0;
    i_in_eol   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge i_clk);
      n++;
      if (o_done) seen = 1'b1;
    end
    chk("done_latency", seen ? n : -1, 3);
    if (seen) chk("busy_at_done", o_busy, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", int'(o_dbg_state), int'(G_IDLE));
    @(posedge i_clk); #1;
  endtask

  task automatic run_frame(input int w, input int h, input bit gap, input int n_out);
    int base;
    base = out_cnt;
    do_start(w, h);
    @(negedge i_clk);
    chk("busy_after_start", o_busy, 1);
    chk("ready_after_start", o_in_ready, 1);
    chk("err_after_start", o_err, 0);
    @(posedge i_clk); #1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        send_beat(r, c, w, gap && !(r == 0 && c == 0), 1'b0);
    wait_done();
    chk("out_count", out_cnt - base, n_out);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic bad_start(input int w, input int h);
    do_start(w, h);
    @(negedge i_clk);
    chk("bad_cfg_err", o_err, 1);
    chk("bad_cfg_busy", o_busy, 0);
    chk("bad_cfg_ready", o_in_ready, 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int cnt_v;
    int cnt_d;
    bit stop;
    i_rst_n = 1'b0; i_start = 1'b0; i_cfg_w_beats = '0; i_cfg_h = '0;
    i_in_valid = 1'b0; i_in_sof = 1'b0; i_in_eol = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_all_zero("reset");
    @(posedge i_clk); #1;

    // W=4 H=6 continuous, then with a bubble before every beat
    run_frame(4, 6, 1'b0, 6);
    run_frame(4, 6, 1'b1, 6);

    // Out-of-range configs, then the minimum legal frame
    bad_start(1, 6);
    bad_start(4, 4);
    bad_start(241, 6);
    run_frame(2, 5, 1'b0, 1);

    // Early in_eol at row 2 col 1
    do_start(4, 6);
    @(posedge i_clk); #1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) send_beat(r, c, 4, 1'b0, 1'b0);
    send_beat(2, 0, 4, 1'b0, 1'b0);
    send_beat(2, 1, 4, 1'b0, 1'b1);
    @(negedge i_clk);
    chk("perr_state", int'(o_dbg_state), int'(G_IDLE));
    chk("perr_err", o_err, 1);
    chk("perr_ready", o_in_ready, 0);
    chk("perr_busy", o_busy, 0);
    cnt_v = 0;
    cnt_d = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_core_in_valid) cnt_v++;
      if (o_done) cnt_d++;
    end
    chk("perr_no_valid", cnt_v, 0);
    chk("perr_no_done", cnt_d, 0);
    @(posedge i_clk); #1;

    // Reset at row 5 of an H=8 frame, then a full fresh frame
    do_start(4, 8);
    @(posedge i_clk); #1;
    stop = 1'b0;
    for (int r = 0; r < 6 && !stop; r++)
      for (int c = 0; c < 4 && !stop; c++) begin
        if (r == 5 && c == 2) stop = 1'b1;
        else send_beat(r, c, 4, 1'b0, 1'b0);
      end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_all_zero("midreset");
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge i_clk); #1;
    run_frame(4, 8, 1'b0, 12);

    repeat (4) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
